// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation over an externally keyed S RAM, decrypting a message ROM into a
// RAM and flagging the key as invalid when a decrypted byte falls outside space/'a'..'z'.
module rc4_prga_decrypt #(
  parameter int unsigned MSG_LEN      = 32,
  parameter int unsigned MSG_AW       = 5,
  parameter bit          ABORT_ON_BAD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              key_invalid,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] e_addr,
  input  logic [7:0]        e_q,
  output logic [MSG_AW-1:0] d_addr,
  output logic [7:0]        d_wdata,
  output logic              d_wren
);

  typedef enum logic [3:0] {
    StIdle, StRdI, StWaitI, StCapI, StRdJ, StWaitJ, StCapJ,
    StWrI, StWrJ, StRdF, StWaitF, StCapF, StWrD, StDone
  } state_e;

  localparam logic [MSG_AW-1:0] KLast = MSG_AW'(MSG_LEN - 1);

  state_e            state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, pt_q, pt_d;
  logic [MSG_AW-1:0] k_q, k_d;

  logic              busy_d, done_d, key_invalid_d, s_wren_d, d_wren_d;
  logic [7:0]        s_addr_d, s_wdata_d, d_wdata_d;
  logic [MSG_AW-1:0] e_addr_d, d_addr_d;
  logic              pt_valid;

  assign pt_valid = (pt_q == 8'h20) || ((pt_q >= 8'h61) && (pt_q <= 8'h7a));

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    si_d          = si_q;
    sj_d          = sj_q;
    pt_d          = pt_q;
    key_invalid_d = key_invalid;
    s_addr_d      = s_addr;
    s_wdata_d     = s_wdata;
    s_wren_d      = 1'b0;
    e_addr_d      = e_addr;
    d_addr_d      = d_addr;
    d_wdata_d     = d_wdata;
    d_wren_d      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          i_d           = 8'd0;
          j_d           = 8'd0;
          k_d           = '0;
          key_invalid_d = 1'b0;
          state_d       = StRdI;
        end
      end
      StRdI: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = StWaitI;
      end
      StWaitI: state_d = StCapI;
      StCapI: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = StRdJ;
      end
      StRdJ: begin
        s_addr_d = j_q;
        state_d  = StWaitJ;
      end
      StWaitJ: state_d = StCapJ;
      StCapJ: begin
        sj_d    = s_q;
        state_d = StWrI;
      end
      StWrI: begin
        s_addr_d  = i_q;
        s_wdata_d = sj_q;
        s_wren_d  = 1'b1;
        state_d   = StWrJ;
      end
      StWrJ: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = StRdF;
      end
      StRdF: begin
        // si+sj is swap-invariant, so the captured values address the post-swap S
        s_addr_d = si_q + sj_q;
        e_addr_d = k_q;
        state_d  = StWaitF;
      end
      StWaitF: state_d = StCapF;
      StCapF: begin
        pt_d    = s_q ^ e_q;
        state_d = StWrD;
      end
      StWrD: begin
        d_addr_d  = k_q;
        d_wdata_d = pt_q;
        d_wren_d  = 1'b1;
        if (!pt_valid) key_invalid_d = 1'b1;
        if ((k_q == KLast) || (ABORT_ON_BAD && !pt_valid)) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          state_d = StRdI;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= '0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      pt_q        <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      key_invalid <= 1'b0;
      s_addr      <= 8'd0;
      s_wdata     <= 8'd0;
      s_wren      <= 1'b0;
      e_addr      <= '0;
      d_addr      <= '0;
      d_wdata     <= 8'd0;
      d_wren      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pt_q        <= pt_d;
      busy        <= busy_d;
      done        <= done_d;
      key_invalid <= key_invalid_d;
      s_addr      <= s_addr_d;
      s_wdata     <= s_wdata_d;
      s_wren      <= s_wren_d;
      e_addr      <= e_addr_d;
      d_addr      <= d_addr_d;
      d_wdata     <= d_wdata_d;
      d_wren      <= d_wren_d;
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: two instances (32 bytes/abort, 9 bytes/no abort) with RAM models,
// an RC4 reference model feeding a write/read-address scoreboard, and a negedge monitor.
module tb_rc4_prga_decrypt;
  localparam int unsigned AW = 5;
  localparam int NDUT = 2;

  typedef struct packed { logic d; logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [7:0] i; logic [7:0] j; logic [7:0] f; logic [7:0] k; } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset [NDUT];
  logic          start [NDUT];
  logic          busy [NDUT], done [NDUT], key_invalid [NDUT], s_wren [NDUT], d_wren [NDUT];
  logic [7:0]    s_addr [NDUT], s_wdata [NDUT], s_q [NDUT], e_q [NDUT], d_wdata [NDUT];
  logic [AW-1:0] e_addr [NDUT], d_addr [NDUT];

  logic [7:0] s_mem [NDUT][256];
  logic [7:0] s_load [NDUT][256];
  logic       load_req [NDUT];
  logic [7:0] rom [NDUT][32];
  logic [7:0] d_mem [NDUT][32];

  logic [7:0] model_s [NDUT][256];
  logic [7:0] exp_d [NDUT][32];
  int         exp_nb [NDUT];
  logic       exp_inv [NDUT];
  wr_t        exp_wr [NDUT][$];
  rd_t        exp_rd [NDUT][$];
  rd_t        cur [NDUT];
  int         cnt [NDUT];
  int         s_wr_cnt [NDUT], d_wr_cnt [NDUT];
  logic [7:0] msg [32];

  int n_tests = 0;
  int n_fail = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    rc4_prga_decrypt #(
      .MSG_LEN     ((g == 0) ? 32 : 9),
      .MSG_AW      (AW),
      .ABORT_ON_BAD((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .start      (start[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .key_invalid(key_invalid[g]),
      .s_addr     (s_addr[g]),
      .s_wdata    (s_wdata[g]),
      .s_wren     (s_wren[g]),
      .s_q        (s_q[g]),
      .e_addr     (e_addr[g]),
      .e_q        (e_q[g]),
      .d_addr     (d_addr[g]),
      .d_wdata    (d_wdata[g]),
      .d_wren     (d_wren[g])
    );
  end

  // Synchronous RAMs/ROM with one cycle of read latency
  always @(posedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (load_req[g]) begin
        for (int n = 0; n < 256; n++) s_mem[g][n] <= s_load[g][n];
      end else if (s_wren[g]) begin
        s_mem[g][s_addr[g]] <= s_wdata[g];
      end
      s_q[g] <= s_mem[g][s_addr[g]];
      e_q[g] <= rom[g][e_addr[g]];
      if (d_wren[g]) d_mem[g][d_addr[g]] <= d_wdata[g];
    end
  end

  task automatic check(input int g, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h, expected %0h", g, name, act, exp);
    end
  endtask

  task automatic mon_step(input int g);
    wr_t w;
    if (busy[g] === 1'b1) cnt[g]++;
    else cnt[g] = 0;
    if (busy[g] === 1'b1) begin
      case (cnt[g] % 12)
        2: begin
          check(g, "read_expected", exp_rd[g].size() > 0, 1);
          if (exp_rd[g].size() > 0) begin
            cur[g] = exp_rd[g].pop_front();
            check(g, "i_read_addr", s_addr[g], cur[g].i);
          end
        end
        5: check(g, "j_read_addr", s_addr[g], cur[g].j);
        10: begin
          check(g, "f_read_addr", s_addr[g], cur[g].f);
          check(g, "e_read_addr", e_addr[g], cur[g].k);
        end
        default: ;
      endcase
    end
    if (s_wren[g] === 1'b1) begin
      s_wr_cnt[g]++;
      check(g, "s_write_expected", exp_wr[g].size() > 0, 1);
      if (exp_wr[g].size() > 0) begin
        w = exp_wr[g].pop_front();
        check(g, "s_write", {1'b0, s_addr[g], s_wdata[g]}, w);
      end
    end
    if (d_wren[g] === 1'b1) begin
      d_wr_cnt[g]++;
      check(g, "d_write_expected", exp_wr[g].size() > 0, 1);
      if (exp_wr[g].size() > 0) begin
        w = exp_wr[g].pop_front();
        check(g, "d_write", {1'b1, 3'b000, d_addr[g], d_wdata[g]}, w);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) mon_step(g);
    end
  end

  // Reference RC4 over plain arrays: predicts reads, writes, plaintext, final S
  task automatic model_run(input int g, input int len, input bit abort);
    int ii, jj, f;
    logic [7:0] si, sj, pt;
    ii = 0;
    jj = 0;
    exp_nb[g] = 0;
    exp_inv[g] = 1'b0;
    for (int k = 0; k < len; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(model_s[g][ii])) % 256;
      si = model_s[g][ii];
      sj = model_s[g][jj];
      exp_wr[g].push_back('{1'b0, 8'(ii), sj});
      exp_wr[g].push_back('{1'b0, 8'(jj), si});
      model_s[g][ii] = sj;
      model_s[g][jj] = si;
      f = (int'(si) + int'(sj)) % 256;
      pt = model_s[g][f] ^ rom[g][k];
      exp_rd[g].push_back('{8'(ii), 8'(jj), 8'(f), 8'(k)});
      exp_wr[g].push_back('{1'b1, 8'(k), pt});
      exp_d[g][k] = pt;
      exp_nb[g]++;
      if (!(pt == 8'h20 || (pt >= 8'h61 && pt <= 8'h7a))) begin
        exp_inv[g] = 1'b1;
        if (abort) break;
      end
    end
  endtask

  task automatic encrypt(input int g, input int len);
    logic [7:0] ss [256];
    logic [7:0] t;
    int ii, jj;
    for (int n = 0; n < 256; n++) ss[n] = model_s[g][n];
    ii = 0;
    jj = 0;
    for (int k = 0; k < len; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ss[ii])) % 256;
      t = ss[ii];
      ss[ii] = ss[jj];
      ss[jj] = t;
      rom[g][k] = msg[k] ^ ss[(int'(ss[ii]) + int'(ss[jj])) % 256];
    end
  endtask

  task automatic ksa_key(input int g);
    logic [7:0] key [3];
    logic [7:0] t;
    int jj;
    key = '{8'h4b, 8'h65, 8'h79};
    for (int n = 0; n < 256; n++) model_s[g][n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + int'(model_s[g][n]) + int'(key[n % 3])) % 256;
      t = model_s[g][n];
      model_s[g][n] = model_s[g][jj];
      model_s[g][jj] = t;
    end
  endtask

  task automatic set_identity(input int g);
    for (int n = 0; n < 256; n++) model_s[g][n] = 8'(n);
  endtask

  task automatic set_perm(input int g);
    logic [7:0] t;
    int r;
    set_identity(g);
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      t = model_s[g][n];
      model_s[g][n] = model_s[g][r];
      model_s[g][r] = t;
    end
  endtask

  task automatic rand_msg();
    int r;
    for (int k = 0; k < 32; k++) begin
      r = $urandom_range(26, 0);
      msg[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
    end
  endtask

  task automatic load_s(input int g);
    for (int n = 0; n < 256; n++) s_load[g][n] = model_s[g][n];
    @(posedge clk);
    #2 load_req[g] = 1'b1;
    @(posedge clk);
    #2 load_req[g] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int g, input string name);
    check(g, name, {busy[g], done[g], key_invalid[g], s_addr[g], s_wdata[g], s_wren[g],
                    e_addr[g], d_addr[g], d_wdata[g], d_wren[g]}, 64'd0);
  endtask

  task automatic launch(input int g, input int len, input bit abort);
    model_run(g, len, abort);
    s_wr_cnt[g] = 0;
    d_wr_cnt[g] = 0;
    @(posedge clk);
    #2 start[g] = 1'b1;
    @(posedge clk);
    #1 check(g, "start_accept", {busy[g], done[g]}, 2'b10);
    start[g] = 1'b0;
  endtask

  task automatic finish_run(input int g, input int len, input bit pulse, output int cyc);
    int nbad;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done[g] === 1'b1 || cyc > 12 * len + 20) break;
      start[g] = pulse && (cyc % 37 == 5);
    end
    start[g] = 1'b0;
    check(g, "done_cycles", cyc, 12 * exp_nb[g]);
    check(g, "key_invalid", key_invalid[g], exp_inv[g]);
    check(g, "busy_in_done", busy[g], 1'b0);
    @(posedge clk);
    #1;
    for (int k = 0; k < exp_nb[g]; k++) check(g, "d_ram", d_mem[g][k], exp_d[g][k]);
    nbad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[g][n] !== model_s[g][n]) nbad++;
    check(g, "final_s_mismatches", nbad, 0);
    check(g, "pending_writes", exp_wr[g].size(), 0);
    check(g, "pending_reads", exp_rd[g].size(), 0);
  endtask

  initial begin
    logic [7:0] kv_ct [9];
    logic [7:0] kv_pt [9];
    int cyc;
    kv_ct = '{8'hbb, 8'hf3, 8'h16, 8'he8, 8'hd9, 8'h40, 8'haf, 8'h0a, 8'hd3};
    kv_pt = '{8'h50, 8'h6c, 8'h61, 8'h69, 8'h6e, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int g = 0; g < NDUT; g++) begin
      reset[g] = 1'b1;
      start[g] = 1'b0;
      load_req[g] = 1'b0;
      cnt[g] = 0;
      for (int k = 0; k < 32; k++) rom[g][k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) check_reset_outputs(g, "reset_outputs");
    for (int g = 0; g < NDUT; g++) reset[g] = 1'b0;

    // Known vector, no abort: "Key" / "Plaintext"
    ksa_key(1);
    for (int k = 0; k < 9; k++) rom[1][k] = kv_ct[k];
    load_s(1);
    launch(1, 9, 1'b0);
    finish_run(1, 9, 1'b0, cyc);
    check(1, "kv_done_cycle", cyc, 108);
    check(1, "kv_key_invalid", key_invalid[1], 1'b1);
    for (int k = 0; k < 9; k++) check(1, "kv_plaintext", d_mem[1][k], kv_pt[k]);

    // Same vector with abort: stops after 'P'
    ksa_key(0);
    for (int k = 0; k < 9; k++) rom[0][k] = kv_ct[k];
    load_s(0);
    launch(0, 32, 1'b1);
    finish_run(0, 32, 1'b0, cyc);
    check(0, "abort_done_cycle", cyc, 12);
    check(0, "abort_key_invalid", key_invalid[0], 1'b1);
    check(0, "abort_s_writes", s_wr_cnt[0], 2);
    check(0, "abort_d_writes", d_wr_cnt[0], 1);
    check(0, "abort_d0", d_mem[0][0], 8'h50);

    // Identity S, valid message, start pulses while busy
    rand_msg();
    set_identity(0);
    encrypt(0, 32);
    load_s(0);
    launch(0, 32, 1'b1);
    finish_run(0, 32, 1'b1, cyc);
    check(0, "id_done_cycle", cyc, 384);
    check(0, "id_key_invalid", key_invalid[0], 1'b0);
    for (int k = 0; k < 32; k++) check(0, "id_plaintext", d_mem[0][k], msg[k]);

    // Reset during byte 5, then silence, then a clean rerun
    set_identity(0);
    encrypt(0, 32);
    load_s(0);
    launch(0, 32, 1'b1);
    repeat (53) @(posedge clk);
    #2 reset[0] = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs(0, "midrun_reset_outputs");
    reset[0] = 1'b0;
    exp_wr[0].delete();
    exp_rd[0].delete();
    s_wr_cnt[0] = 0;
    d_wr_cnt[0] = 0;
    repeat (40) @(posedge clk);
    #1;
    check(0, "post_reset_s_writes", s_wr_cnt[0], 0);
    check(0, "post_reset_d_writes", d_wr_cnt[0], 0);
    check(0, "post_reset_busy", busy[0], 1'b0);
    set_identity(0);
    encrypt(0, 32);
    load_s(0);
    launch(0, 32, 1'b1);
    finish_run(0, 32, 1'b0, cyc);
    for (int k = 0; k < 32; k++) check(0, "rerun_plaintext", d_mem[0][k], msg[k]);

    // Random wrapping S with a bad ROM, then restart from DONE with a good one
    set_perm(0);
    for (int k = 0; k < 32; k++) rom[0][k] = 8'($urandom);
    load_s(0);
    launch(0, 32, 1'b1);
    finish_run(0, 32, 1'b0, cyc);
    rand_msg();
    set_perm(0);
    encrypt(0, 32);
    load_s(0);
    launch(0, 32, 1'b1);
    finish_run(0, 32, 1'b0, cyc);
    check(0, "restart_key_invalid", key_invalid[0], 1'b0);
    for (int k = 0; k < 32; k++) check(0, "perm_plaintext", d_mem[0][k], msg[k]);

    // Random S and ROM on the no-abort instance: all bytes processed
    for (int t = 0; t < 3; t++) begin
      set_perm(1);
      for (int k = 0; k < 9; k++) rom[1][k] = 8'($urandom);
      load_s(1);
      launch(1, 9, 1'b0);
      finish_run(1, 9, 1'b0, cyc);
      check(1, "noabort_done_cycle", cyc, 108);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
